// File: rtl/reg_scoreboard.sv
// Register scoreboard for a 16-entry register file.
// It keeps one pending-write bit per register, holds back an instruction
// whose sources or destination have a write still outstanding, and counts
// the cycles it spends stalled.
//
// Handshake: the decode stage offers an instruction with issue_valid.
// issue_ready is computed from the current inputs and never looks at
// issue_valid. The instruction issues on a rising edge where both are high.
// The instruction must stay presented until that edge. Writebacks
// (wb_valid) have no back-pressure and are always accepted.
module reg_scoreboard #(
    parameter int CNT_W = 8,
    parameter int NREG  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [3:0]       RS1,
    input  logic [3:0]       RS2,
    input  logic [3:0]       RS3,
    input  logic             rd_en,
    input  logic [3:0]       RD,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [3:0]       wb_rd,
    input  logic             flush,
    output logic [NREG-1:0]  busy,
    output logic [4:0]       inflight,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_wb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] eb;
    logic [NREG-1:0] busy_nxt;
    logic            fire;
    logic            wb_err;

    // A retiring write is treated as already done when checking the
    // instruction in the same cycle (writeback bypass).
    always_comb begin
        wb_mask = '0;
        if (wb_valid) begin
            wb_mask[wb_rd] = 1'b1;
        end
        eb = busy & ~wb_mask;
    end

    // Stall when any source is pending, or when the destination still has a
    // pending write (WAW). A flush blocks issue outright.
    always_comb begin
        issue_ready = 1'b0;
        if (!flush) begin
            issue_ready = !(eb[RS1] || eb[RS2] || eb[RS3] || (rd_en && eb[RD]));
        end
        hazard = issue_valid && !issue_ready;
        fire   = issue_valid && issue_ready;
    end

    // Next pending set: flush wins over everything. The writeback clear is
    // applied first, so a same-cycle issue to the same register keeps it busy.
    always_comb begin
        busy_nxt = '0;
        if (!flush) begin
            busy_nxt = busy & ~wb_mask;
            if (fire && rd_en) begin
                busy_nxt[RD] = 1'b1;
            end
        end
        wb_err = wb_valid && !flush && !busy[wb_rd];
    end

    // Pending bits and their population count move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            inflight <= '0;
        end else begin
            busy     <= busy_nxt;
            inflight <= 5'($countones(busy_nxt));
        end
    end

    // Saturating count of stalled cycles. A flush does not reset it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Sticky flag: a writeback arrived for a register with no pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_wb <= 1'b0;
        end else if (wb_err) begin
            err_wb <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus randomized traffic,
// checked against a set-of-pending-registers model.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [3:0]  RS1, RS2, RS3, RD;
    logic        rd_en;
    logic        issue_ready;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        flush;
    logic [15:0] busy;
    logic [4:0]  inflight;
    logic        hazard;
    logic [7:0]  stall_cnt;
    logic        err_wb;

    int n_cmp;
    int n_err;

    // Model: which registers owe a write, sticky error, stall count.
    bit pend[16];
    bit m_err;
    int m_stall;

    bit o_rdy, o_haz;

    reg_scoreboard #(.CNT_W(8), .NREG(16)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .RS1(RS1), .RS2(RS2), .RS3(RS3), .rd_en(rd_en), .RD(RD),
        .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush), .busy(busy), .inflight(inflight), .hazard(hazard),
        .stall_cnt(stall_cnt), .err_wb(err_wb)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit still_pending(input bit [3:0] r, input bit wv, input bit [3:0] wr);
        return pend[r] && !(wv && (wr == r));
    endfunction

    task automatic check_regs();
        logic [15:0] ev;
        int cnt;
        ev = '0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            ev[i] = pend[i];
            cnt += int'(pend[i]);
        end
        check("busy", busy, ev);
        check("inflight", inflight, cnt);
        check("stall_cnt", stall_cnt, m_stall);
        check("err_wb", err_wb, m_err);
    endtask

    task automatic drive_idle();
        issue_valid = 0; RS1 = 0; RS2 = 0; RS3 = 0; rd_en = 0; RD = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) pend[i] = 0;
        m_err = 0;
        m_stall = 0;
    endtask

    // One clock of traffic: present inputs, check combinational outputs,
    // take the edge, advance the model, check registered outputs.
    task automatic step(input bit iv, input bit [3:0] r1, input bit [3:0] r2, input bit [3:0] r3,
                        input bit rde, input bit [3:0] rd, input bit wv, input bit [3:0] wr,
                        input bit fl, output bit rdy_o, output bit haz_o);
        bit blocked, e_rdy, e_haz, bad_wb;
        @(negedge clk);
        issue_valid = iv; RS1 = r1; RS2 = r2; RS3 = r3; rd_en = rde; RD = rd;
        wb_valid = wv; wb_rd = wr; flush = fl;
        #1;
        blocked = still_pending(r1, wv, wr) || still_pending(r2, wv, wr) ||
                  still_pending(r3, wv, wr) || (rde && still_pending(rd, wv, wr));
        e_rdy = !fl && !blocked;
        e_haz = iv && !e_rdy;
        check("issue_ready", issue_ready, e_rdy);
        check("hazard", hazard, e_haz);
        rdy_o = issue_ready;
        haz_o = hazard;
        @(posedge clk);
        bad_wb = wv && !pend[wr];
        if (e_haz && m_stall < 255) m_stall++;
        if (fl) begin
            for (int i = 0; i < 16; i++) pend[i] = 0;
        end else begin
            if (bad_wb) m_err = 1;
            if (wv) pend[wr] = 0;
            if (iv && e_rdy && rde) pend[rd] = 1;
        end
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 0;
        #1;
        clear_model();
        check("rst_busy", busy, 16'h0000);
        check("rst_inflight", inflight, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_err", err_wb, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic rand_step();
        bit iv, rde, wv, fl;
        bit [3:0] r1, r2, r3, rd, wr;
        iv = ($urandom_range(0, 3) != 0);
        r1 = 4'($urandom_range(0, 15));
        r2 = 4'($urandom_range(0, 15));
        r3 = 4'($urandom_range(0, 15));
        rde = ($urandom_range(0, 3) != 0);
        rd = 4'($urandom_range(0, 15));
        wv = ($urandom_range(0, 1) != 0);
        wr = 4'($urandom_range(0, 15));
        if (wv && $urandom_range(0, 7) != 0) begin
            for (int k = 0; k < 16; k++) begin
                if (pend[4'(wr + k)]) begin
                    wr = 4'(wr + k);
                    break;
                end
            end
        end
        fl = ($urandom_range(0, 40) == 0);
        step(iv, r1, r2, r3, rde, rd, wv, wr, fl, o_rdy, o_haz);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_model();
        drive_idle();
        rst_n = 0;
        #12;
        check("init_busy", busy, 16'h0000);
        check("init_inflight", inflight, 0);
        check("init_stall", stall_cnt, 0);
        check("init_err", err_wb, 0);
        @(negedge clk);
        rst_n = 1;

        // Issue RD=5, then a consumer of r5 stalls.
        step(1, 0, 0, 0, 1, 5, 0, 0, 0, o_rdy, o_haz);
        check("r22_busy", busy, 16'h0020);
        check("r22_inflight", inflight, 1);
        step(1, 1, 5, 2, 0, 0, 0, 0, 0, o_rdy, o_haz);
        check("r22_hazard", o_haz, 1);
        check("r22_ready", o_rdy, 0);

        // Writeback bypass lets the reader of r5 go in the same cycle.
        step(1, 5, 0, 0, 0, 0, 1, 5, 0, o_rdy, o_haz);
        check("r23_ready", o_rdy, 1);
        check("r23_busy5", busy[5], 0);

        // Same-cycle issue and writeback to r3: the set wins, no error.
        do_reset();
        step(1, 3, 3, 3, 1, 3, 0, 0, 0, o_rdy, o_haz);
        step(1, 3, 0, 0, 1, 3, 1, 3, 0, o_rdy, o_haz);
        check("r24_ready", o_rdy, 1);
        check("r24_busy3", busy[3], 1);
        check("r24_err", err_wb, 0);

        // Stray writeback sets a sticky error; idle inputs carry junk indices.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, 9, 0, o_rdy, o_haz);
        check("r25_err", err_wb, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0, 0, 0, o_rdy, o_haz);
        end
        check("r25_err_hold", err_wb, 1);

        // Writeback arriving during a flush does not raise the error.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, 11, 1, o_rdy, o_haz);
        check("flush_wb_err", err_wb, 0);

        // Long stall saturates the counter (register 0 tracked normally).
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, o_rdy, o_haz);
        for (int i = 0; i < 300; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, o_rdy, o_haz);
        end
        check("r26_stall", stall_cnt, 255);

        // Fill every register, then flush against a concurrent issue.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 4'(i), 4'(i), 4'(i), 1, 4'(i), 0, 0, 0, o_rdy, o_haz);
        end
        check("r27_full", busy, 16'hFFFF);
        check("r27_full_cnt", inflight, 16);
        step(1, 0, 0, 0, 1, 2, 0, 0, 1, o_rdy, o_haz);
        check("r27_flush_busy", busy, 16'h0000);
        check("r27_flush_cnt", inflight, 0);
        check("r27_flush_stall", stall_cnt, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) rand_step();

        // Reset asserted in the middle of a stall.
        step(1, 0, 0, 0, 1, 7, 0, 0, 0, o_rdy, o_haz);
        @(negedge clk);
        issue_valid = 1; RS1 = 7; RS2 = 0; RS3 = 0; rd_en = 0; RD = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
        #1;
        check("mid_haz_pre", hazard, pend[7] ? 1 : 0);
        #1;
        rst_n = 0;
        #1;
        clear_model();
        check("mid_busy", busy, 16'h0000);
        check("mid_inflight", inflight, 0);
        check("mid_stall", stall_cnt, 0);
        check("mid_err", err_wb, 0);
        check("mid_hazard", hazard, 0);
        check("mid_ready", issue_ready, 1);
        drive_idle();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 500; i++) rand_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
